// File: rtl/readback_status_n.sv
// Readback status block: header alignment checks, lockup timers and a
// short tagged status frame streamed out on request.
module readback_status_n #(
   parameter int          NCH    = 2,
   parameter logic [19:0] TMO    = 20'hE0000,
   parameter int          TWD_HI = 4,
   parameter int          TWD_LO = 5
) (
   input  logic              clk128,
   input  logic              init,
   input  logic [4:0]        crate,
   input  logic              rd,
   input  logic [NCH-1:0]    active,
   input  logic [NCH-1:0]    eob,
   input  logic [24*NCH-1:0] readcount,
   input  logic [11:0]       linkword,
   input  logic              linkfst,
   input  logic              linkdav,
   input  logic [7:0]        lock,
   input  logic [5:0]        ext_status,
   input  logic              clr_err,
   output logic              read,
   output logic [9:0]        bytout,
   output logic              error
);

   localparam int         FLEN = 4 + NCH;
   localparam logic [2:0] HI3  = 3'(TWD_HI);
   localparam logic [2:0] LO3  = 3'(TWD_LO);
   localparam logic [3:0] FL4  = 4'(FLEN);

   typedef enum logic {IDLE, SEND} st_t;

   logic [2:0]     hedwd;
   logic [NCH-1:0] align_err;
   logic [NCH-1:0] time_err;
   logic [NCH-1:0] timer;
   logic [NCH-1:0] active_d;
   logic [NCH-1:0] mism;
   logic [5:0]     mm_cnt   [NCH];
   logic [19:0]    tcnt     [NCH];
   logic [19:0]    tcnt_nxt [NCH];
   logic [15:0]    status;

   st_t         state, state_nxt;
   logic [3:0]  idx, idx_nxt, wsel;
   logic        read_nxt, load;
   logic [9:0]  byt_nxt, word;
   logic [15:0] sn_stat;
   logic [4:0]  sn_crate;
   logic [7:0]  sn_ch [NCH];

   always_ff @(posedge clk128 or posedge init) begin
      if (init) begin
         hedwd <= '0;
      end else if (~|active) begin
         hedwd <= '0;
      end else if (linkfst) begin
         hedwd <= 3'd1;
      end else if (linkdav) begin
         if (hedwd == LO3)
            hedwd <= '0;
         else if (hedwd != 3'd0)
            hedwd <= hedwd + 3'd1;
      end
   end

   // A linkdav swallowed by a coincident linkfst is not a header word.
   always_comb begin
      mism = '0;
      for (int c = 0; c < NCH; c++) begin
         tcnt_nxt[c] = '0;
         if (active[c] && linkdav && !linkfst) begin
            if (hedwd == HI3 && linkword != readcount[24*c+12 +: 12])
               mism[c] = 1'b1;
            if (hedwd == LO3 && linkword != readcount[24*c +: 12])
               mism[c] = 1'b1;
         end
         if (timer[c])
            tcnt_nxt[c] = (&tcnt[c]) ? tcnt[c] : tcnt[c] + 20'd1;
      end
   end

   always_ff @(posedge clk128 or posedge init) begin
      if (init) begin
         align_err <= '0;
         time_err  <= '0;
         timer     <= '0;
         active_d  <= '0;
         for (int c = 0; c < NCH; c++) begin
            mm_cnt[c] <= '0;
            tcnt[c]   <= '0;
         end
      end else begin
         active_d <= active;
         for (int c = 0; c < NCH; c++) begin
            if (mism[c]) begin
               align_err[c] <= 1'b1;
               if (clr_err)
                  mm_cnt[c] <= 6'd1;
               else if (mm_cnt[c] != 6'd63)
                  mm_cnt[c] <= mm_cnt[c] + 6'd1;
            end else if (clr_err) begin
               align_err[c] <= 1'b0;
               mm_cnt[c]    <= '0;
            end
            // Rising edge wins over a coincident end-of-block.
            if (active[c] && !active_d[c])
               timer[c] <= 1'b1;
            else if (active[c] && eob[c])
               timer[c] <= 1'b0;
            tcnt[c] <= tcnt_nxt[c];
            if (tcnt_nxt[c] > TMO)
               time_err[c] <= 1'b1;
            else if (clr_err)
               time_err[c] <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk128 or posedge init) begin
      if (init)
         error <= 1'b0;
      else
         error <= (|align_err) | (|time_err);
   end

   assign status = {|align_err, |time_err, ext_status, lock};
   assign wsel   = idx + 4'd1;

   always_comb begin
      word = '0;
      if (wsel == 4'd2)
         word = {2'b00, 3'b000, sn_crate};
      else if (wsel == 4'd3)
         word = {2'b11, sn_stat[15:8]};
      else if (wsel == 4'd4)
         word = {2'b00, sn_stat[7:0]};
      else
         for (int k = 0; k < NCH; k++)
            if (wsel == 4'(5 + k))
               word = {2'b10, sn_ch[k]};
   end

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      read_nxt  = read;
      byt_nxt   = bytout;
      load      = 1'b0;
      unique case (state)
         IDLE: begin
            idx_nxt  = '0;
            read_nxt = 1'b0;
            byt_nxt  = '0;
            if (rd) begin
               state_nxt = SEND;
               load      = 1'b1;
               idx_nxt   = 4'd1;
               read_nxt  = 1'b1;
               byt_nxt   = {2'b01, 8'hFF};
            end
         end
         SEND: begin
            if (idx == FL4) begin
               state_nxt = IDLE;
               idx_nxt   = '0;
               read_nxt  = 1'b0;
               byt_nxt   = '0;
            end else begin
               idx_nxt = wsel;
               byt_nxt = word;
            end
         end
      endcase
   end

   always_ff @(posedge clk128 or posedge init) begin
      if (init) begin
         state    <= IDLE;
         idx      <= '0;
         read     <= 1'b0;
         bytout   <= '0;
         sn_stat  <= '0;
         sn_crate <= '0;
         for (int k = 0; k < NCH; k++)
            sn_ch[k] <= '0;
      end else begin
         state  <= state_nxt;
         idx    <= idx_nxt;
         read   <= read_nxt;
         bytout <= byt_nxt;
         // Frozen copy keeps the frame in flight immune to error updates.
         if (load) begin
            sn_stat  <= status;
            sn_crate <= crate;
            for (int k = 0; k < NCH; k++)
               sn_ch[k] <= {align_err[k], time_err[k], mm_cnt[k]};
         end
      end
   end

endmodule

// File: doc/readback_status_n.md
READBACK_STATUS_N -- requirements
Module: readback_status_n

Interface
REQ-001 Parameter NCH, default 2: number of readout channels checked, legal range 1..8.
REQ-002 Parameter TMO, default 20'hE0000: lockup timeout limit, in clk128 cycles.
REQ-003 Parameter TWD_HI, default 4: header word index compared against trigger count bits [23:12].
REQ-004 Parameter TWD_LO, default 5: header word index compared against trigger count bits [11:0]; TWD_LO = TWD_HI+1 and TWD_LO <= 7.
REQ-005 clk128  in  1: single clock; every register in the block is on its rising edge.
REQ-006 init  in  1: reset, asynchronous, active-high.
REQ-007 crate  in  5: crate number, quasi-static.
REQ-008 rd  in  1: readback request strobe, one cycle.
REQ-009 active  in  NCH: per-channel readout active level, synchronous to clk128.
REQ-010 eob  in  NCH: per-channel end-of-block pulse.
REQ-011 readcount  in  24*NCH: per-channel expected trigger number; channel c occupies bits [24c+23:24c].
REQ-012 linkword  in  12: link data word.
REQ-013 linkfst  in  1: first header word strobe.
REQ-014 linkdav  in  1: link data valid.
REQ-015 lock  in  8: PLL/DPA/transmitter lock flags.
REQ-016 ext_status  in  6: optical-status and busy flags.
REQ-017 clr_err  in  1: synchronous clear of sticky errors and counters.
REQ-018 read  out  1: readback frame in progress.
REQ-019 bytout  out  10: registered frame word, {2-bit tag, 8-bit data}.
REQ-020 error  out  1: OR of all sticky alignment and timeout errors.

Function
REQ-021 Header word counter hedwd, 3 bits: cleared when no active bit is set; otherwise set to 1 on linkfst.
REQ-022 hedwd update rules: linkfst has priority over a coincident linkdav; each linkdav with hedwd in 1..TWD_LO-1 increments hedwd; linkdav at TWD_LO returns hedwd to 0; linkdav at hedwd=0 is ignored.
REQ-023 For each channel c with active[c]=1: linkdav at hedwd=TWD_HI with linkword != readcount_c[23:12], or at hedwd=TWD_LO with linkword != readcount_c[11:0], sets sticky align_err[c] and increments 6-bit mm_cnt[c].
REQ-024 mm_cnt saturates at 63 and never wraps.
REQ-025 Per-channel timer[c] sets on the rising edge of active[c] and clears on active[c]&eob[c]; a coincident rise and eob leaves timer set.
REQ-026 Per-channel 20-bit tcnt[c] is held at 0 while timer[c]=0, otherwise increments.
REQ-027 tcnt[c] saturates at 20'hFFFFF.
REQ-028 time_err[c] sets when tcnt[c] > TMO, and is sticky.
REQ-029 clr_err clears align_err, mm_cnt and time_err for all channels; a coincident set condition wins, with mm_cnt becoming 1.
REQ-030 error = OR of all align_err and time_err, registered with one cycle of latency.
REQ-031 status[15:0] = {|align_err, |time_err, ext_status[5:0], lock[7:0]}.
REQ-032 Readout FSM has states IDLE and SEND; rd in IDLE snapshots status, crate and the per-channel fields, moves to SEND, and sets read=1 and idx=1 at the same edge.
REQ-033 In SEND, idx increments each cycle; the edge after idx=FLEN=4+NCH returns the FSM to IDLE with read=0 and bytout=0.
REQ-034 Frame word 1 = {01,FF}; word 2 = {00,3'b0,crate}; word 3 = {11,status[15:8]}; word 4 = {00,status[7:0]}.
REQ-035 Frame word 4+k+1 = {10, align_err[k], time_err[k], mm_cnt[k]} for k = 0..NCH-1.
REQ-036 rd in SEND is ignored.
REQ-037 Error updates and clr_err during SEND do not alter the frame in flight.
REQ-038 bytout=0 whenever read=0.

Reset
REQ-039 init asserted clears hedwd, align_err, mm_cnt, timer, tcnt, time_err, error, read, idx and bytout to 0 and forces the FSM to IDLE, immediately and independent of clk128.
REQ-040 init asserted mid-frame aborts the frame; the first rd after init deasserts starts a complete new frame.

Verification
REQ-041 NCH=2, crate=5, lock=8'h1F, ext_status=0, rd pulse -> read high for 6 cycles, bytout = 1FF, 005, 300, 01F, 200, 200, then 000.
REQ-042 active=01, readcount_0=24'h123456, header sequence with word4=12'h123, word5=12'h457 -> align_err[0]=1, mm_cnt[0]=1, error=1 one cycle later; channel 1 unaffected.
REQ-043 TMO=100, rising edge on active[1] with no eob -> time_err[1] sets on the cycle tcnt[1]=101; eob before that cycle -> no error.
REQ-044 64 mismatching headers -> mm_cnt=63; clr_err coincident with a further mismatch -> mm_cnt=1 and align_err=1.
REQ-045 rd repeated during SEND, and init pulsed at idx=3 -> no frame restart during SEND; after init all outputs are 0 and the next rd yields a full frame.
